// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write-side and read-side controllers.
// Gray helpers run on 32 bits; callers zero-extend their operands and truncate the result.
package fifo_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into the local clock domain.
// Both stages reset to zero.
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] rq1_q, rq2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= d;
      rq2_q <= rq1_q;
    end
  end

  assign q = rq2_q;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: the write pointer, the registered memory write port,
// and the full, almost_full, level and overflow flags derived from the synchronized read pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = 12
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W:0]   rq2;
  logic [ADDR_W:0]   wbin_q, wbin_d, rbin;
  logic [ADDR_W:0]   wgray_q, wgray_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d, af_q, af_d, ovf_q, ovf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_acc;

  sync_2ff #(.W(ADDR_W+1)) u_rptr_sync (
    .clk  (wclk),
    .rst_n(rst_n),
    .d    (rd_ptr_gray),
    .q    (rq2)
  );

  always_comb begin
    wr_acc  = wr_en & ~full_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wr_acc};
    wgray_d = (ADDR_W+1)'(bin2gray(32'(wbin_d)));
    rbin    = (ADDR_W+1)'(gray2bin(32'(rq2)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]});
    level_d = wbin_d - rbin;
    af_d    = (level_d >= AF_LVL);
    mem_we_d    = wr_acc;
    mem_waddr_d = wr_acc ? wbin_q[ADDR_W-1:0] : mem_waddr_q;
    mem_wdata_d = wr_acc ? wr_data : mem_wdata_q;
    // A new overflow event beats a clear in the same cycle.
    ovf_d = (wr_en & full_q) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ovf_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      level_q     <= level_d;
      full_q      <= full_d;
      af_q        <= af_d;
      ovf_q       <= ovf_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: fill, overflow, full release latency, pointer wrap, mid-write reset.
module tb_fifo_wr_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          wclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic          mem_we, full, almost_full, overflow;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   wr_ptr_gray, wr_level;

  int n_chk = 0;
  int n_err = 0;

  fifo_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(12)) dut (
    .wclk       (wclk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .ovf_clr    (ovf_clr),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wr_ptr_gray(wr_ptr_gray),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .overflow   (overflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW:0] gry(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, ".we"},    32'(mem_we), 0);
    chk({tag, ".addr"},  32'(mem_waddr), 0);
    chk({tag, ".data"},  32'(mem_wdata), 0);
    chk({tag, ".gray"},  32'(wr_ptr_gray), 0);
    chk({tag, ".full"},  32'(full), 0);
    chk({tag, ".af"},    32'(almost_full), 0);
    chk({tag, ".level"}, 32'(wr_level), 0);
    chk({tag, ".ovf"},   32'(overflow), 0);
  endtask

  initial begin
    logic [AW:0] prev_g;

    // Reset state
    #12;
    chk_rst_vals("rst");
    @(negedge wclk);
    rst_n = 1'b1;
    tick;

    // 16 back-to-back writes with no reads; almost_full tracked along the way
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i + 1);
      tick;
      chk($sformatf("fill.we%0d", i),    32'(mem_we), 1);
      chk($sformatf("fill.addr%0d", i),  32'(mem_waddr), i);
      chk($sformatf("fill.data%0d", i),  32'(mem_wdata), i + 1);
      chk($sformatf("fill.level%0d", i), 32'(wr_level), i + 1);
      chk($sformatf("fill.af%0d", i),    32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk($sformatf("fill.full%0d", i),  32'(full), (i == 15) ? 1 : 0);
    end
    chk("fill.gray", 32'(wr_ptr_gray), 32'h18);

    // Write while full is dropped and sets overflow
    wr_data = 16'hDEAD;
    tick;
    chk("ovf.we",   32'(mem_we), 0);
    chk("ovf.gray", 32'(wr_ptr_gray), 32'h18);
    chk("ovf.data", 32'(mem_wdata), 32'h10);
    chk("ovf.set",  32'(overflow), 1);
    ovf_clr = 1'b1;
    tick;
    chk("ovf.setwins", 32'(overflow), 1);
    wr_en = 1'b0;
    tick;
    chk("ovf.clr", 32'(overflow), 0);
    ovf_clr = 1'b0;

    // One read: full drops exactly 3 edges after rd_ptr_gray changes
    rd_ptr_gray = 5'b00001;
    tick;
    chk("rel.full1", 32'(full), 1);
    tick;
    chk("rel.full2", 32'(full), 1);
    tick;
    chk("rel.full3", 32'(full), 0);
    chk("rel.level", 32'(wr_level), 15);
    wr_en = 1'b1;
    wr_data = 16'h0011;
    tick;
    chk("rel.we",    32'(mem_we), 1);
    chk("rel.addr",  32'(mem_waddr), 0);
    chk("rel.full",  32'(full), 1);
    chk("rel.level16", 32'(wr_level), 16);
    wr_en = 1'b0;

    // Fresh start, then 40 writes with the read side draining immediately
    rst_n = 1'b0;
    rd_ptr_gray = '0;
    #3;
    rst_n = 1'b1;
    tick;
    prev_g = wr_ptr_gray;
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1;
      wr_data = DW'(16'h0100 + k);
      tick;
      chk($sformatf("wrap.addr%0d", k), 32'(mem_waddr), k % 16);
      chk($sformatf("wrap.gray%0d", k), 32'(wr_ptr_gray), 32'(gry(AW'(0) + 5'((k + 1) % 32))));
      chk($sformatf("wrap.onebit%0d", k), $countones(prev_g ^ wr_ptr_gray), 1);
      chk($sformatf("wrap.full%0d", k), 32'(full), 0);
      prev_g = wr_ptr_gray;
      rd_ptr_gray = gry(5'((k + 1) % 32));
    end
    wr_en = 1'b0;
    repeat (4) tick;
    chk("wrap.level0", 32'(wr_level), 0);
    chk("wrap.gray8",  32'(wr_ptr_gray), 32'h0C);

    // Reset pulsed right after an accepted write
    wr_en = 1'b1;
    wr_data = 16'h55AA;
    tick;
    chk("mid.we",   32'(mem_we), 1);
    chk("mid.addr", 32'(mem_waddr), 8);
    wr_en = 1'b0;
    rst_n = 1'b0;
    rd_ptr_gray = '0;
    #1;
    chk_rst_vals("mid");
    #2;
    rst_n = 1'b1;
    tick;
    wr_en = 1'b1;
    wr_data = 16'hBEEF;
    tick;
    chk("post.we",   32'(mem_we), 1);
    chk("post.addr", 32'(mem_waddr), 0);
    chk("post.data", 32'(mem_wdata), 32'hBEEF);
    wr_en = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
